clkgen_prog: RTL and testbench

CLKGEN_PROG -- requirements
Module: clkgen_prog

---
 rtl/clkgen_pkg.sv | 11 +
 rtl/clkgen_prog.sv | 68 ++++++
 tb/tb_clkgen_prog.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
// Shared constants for the programmable clock generator.
// half_count() turns a target output frequency into a half-period terminal count.
package clkgen_pkg;

  localparam int SYS_CLK_HZ = 100_000_000;

  function automatic int half_count(input int f_out);
    return SYS_CLK_HZ / (2 * f_out) - 1;
  endfunction

endpackage

// File: rtl/clkgen_prog.sv
// Programmable 50% duty clock divider with a double-buffered divisor.
// A new divisor only takes effect at a rising output edge so no phase is ever cut short.
module clkgen_prog
  import clkgen_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = half_count(200_000)
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_half,
  input  logic             div_load,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             div_ack,
  output logic             pend_valid
);

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_act;
  logic [CNT_W-1:0] pending;
  logic             toggle;
  logic             apply;

  // Divisor handshake: div_load is a fire-and-forget strobe (no backpressure);
  // pend_valid marks an unapplied value, and div_ack pulses once when it becomes active.
  assign toggle = enable && (cnt == half_act);
  assign apply  = toggle && !clk_out && pend_valid;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt        <= '0;
      clk_out    <= 1'b1;
      half_act   <= DEF_HALF;
      pending    <= DEF_HALF;
      pend_valid <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      if (toggle) begin
        cnt <= '0;
      end else if (enable) begin
        cnt <= cnt + CNT_W'(1);
      end
      clk_out   <= clk_out ^ toggle;
      rise_tick <= toggle && !clk_out;
      fall_tick <= toggle && clk_out;
      div_ack   <= apply;
      if (apply) begin
        half_act <= pending;
      end
      // A load coinciding with an apply wins: the old value moves to half_act,
      // the new one stays pending.
      if (div_load) begin
        pending    <= div_half;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clkgen_prog.sv
// Self-checking bench for clkgen_prog: directed scenarios plus random traffic,
// all checked against a phase-length reference model.
module tb_clkgen_prog;

  localparam int CNT_W = 8;
  localparam int DEF   = 249;

  logic             clk_100MHz = 1'b0;
  logic             reset      = 1'b1;
  logic             enable     = 1'b0;
  logic [CNT_W-1:0] div_half   = '0;
  logic             div_load   = 1'b0;
  logic             clk_out, rise_tick, fall_tick, div_ack, pend_valid;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Reference model: output level plus the number of enabled cycles left in the phase.
  logic m_lvl, m_rise, m_fall, m_ack, m_pv;
  int   m_left, m_act, m_pend;

  clkgen_prog #(.CNT_W(CNT_W)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .enable     (enable),
    .div_half   (div_half),
    .div_load   (div_load),
    .clk_out    (clk_out),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .div_ack    (div_ack),
    .pend_valid (pend_valid)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic tick();
    @(posedge clk_100MHz);
    cyc++;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_ack  = 1'b0;
    if (reset) begin
      m_lvl  = 1'b1;
      m_left = DEF + 1;
      m_act  = DEF;
      m_pend = DEF;
      m_pv   = 1'b0;
    end else begin
      if (enable) begin
        m_left--;
        if (m_left == 0) begin
          m_lvl = !m_lvl;
          if (m_lvl) begin
            m_rise = 1'b1;
            if (m_pv) begin
              m_act = m_pend;
              m_ack = 1'b1;
            end
          end else begin
            m_fall = 1'b1;
          end
          m_left = m_act + 1;
        end
      end
      if (div_load) begin
        m_pend = int'(div_half);
        m_pv   = 1'b1;
      end else if (m_ack) begin
        m_pv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    div_load = 1'b0;
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    enable   = 1'b1;
    div_load = 1'b1;
    div_half = 8'd7;
    tick();
    tick();
    vectors++;
    if ({clk_out, rise_tick, fall_tick, div_ack, pend_valid} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_state got=%b exp=%b", {clk_out, rise_tick, fall_tick, div_ack, pend_valid}, 5'b10000);
    end
    div_load = 1'b0;
    reset    = 1'b0;
    cyc      = 0;
  endtask

  task automatic test_default_period();
    int fall_c = -1, rise1 = -1, rise2 = -1;
    enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      vectors++;
      if ({clk_out, rise_tick, fall_tick, div_ack, pend_valid} !== {m_lvl, m_rise, m_fall, m_ack, m_pv}) begin
        miscompares++;
        $display("FAIL default_model cyc=%0d got=%b exp=%b", cyc, {clk_out, rise_tick, fall_tick, div_ack, pend_valid}, {m_lvl, m_rise, m_fall, m_ack, m_pv});
      end
      if (fall_tick && fall_c < 0) fall_c = cyc;
      if (rise_tick) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
    end
    vectors++;
    if (fall_c != 250) begin
      miscompares++;
      $display("FAIL default_first_fall got=%0d exp=250", fall_c);
    end
    vectors++;
    if (rise1 != 500) begin
      miscompares++;
      $display("FAIL default_first_rise got=%0d exp=500", rise1);
    end
    vectors++;
    if (rise2 != 1000) begin
      miscompares++;
      $display("FAIL default_period got=%0d exp=1000", rise2);
    end
  endtask

  task automatic test_load();
    int pv_c = -1, ack_c = -1, fall_c = -1, rise_c = -1;
    do_reset();
    enable   = 1'b1;
    div_half = 8'd4;
    for (int i = 0; i < 515; i++) begin
      div_load = (cyc == 100);
      tick();
      vectors++;
      if ({clk_out, rise_tick, fall_tick, div_ack, pend_valid} !== {m_lvl, m_rise, m_fall, m_ack, m_pv}) begin
        miscompares++;
        $display("FAIL load_model cyc=%0d got=%b exp=%b", cyc, {clk_out, rise_tick, fall_tick, div_ack, pend_valid}, {m_lvl, m_rise, m_fall, m_ack, m_pv});
      end
      if (pend_valid && pv_c < 0) pv_c = cyc;
      if (div_ack && ack_c < 0) ack_c = cyc;
      if (ack_c >= 0 && fall_tick && fall_c < 0) fall_c = cyc;
      if (ack_c >= 0 && cyc > ack_c && rise_tick && rise_c < 0) rise_c = cyc;
    end
    div_load = 1'b0;
    vectors++;
    if (pv_c != 101) begin
      miscompares++;
      $display("FAIL load_pend_valid got=%0d exp=101", pv_c);
    end
    vectors++;
    if (ack_c != 500) begin
      miscompares++;
      $display("FAIL load_ack_cycle got=%0d exp=500", ack_c);
    end
    vectors++;
    if (fall_c != 505 || rise_c != 510) begin
      miscompares++;
      $display("FAIL load_new_period got=%0d/%0d exp=505/510", fall_c, rise_c);
    end
  endtask

  task automatic test_double_load();
    int acks = 0, r0 = -1, r1 = -1;
    enable   = 1'b1;
    div_load = 1'b1;
    div_half = 8'd9;
    tick();
    div_half = 8'd3;
    tick();
    div_load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      vectors++;
      if ({clk_out, rise_tick, fall_tick, div_ack, pend_valid} !== {m_lvl, m_rise, m_fall, m_ack, m_pv}) begin
        miscompares++;
        $display("FAIL double_model cyc=%0d got=%b exp=%b", cyc, {clk_out, rise_tick, fall_tick, div_ack, pend_valid}, {m_lvl, m_rise, m_fall, m_ack, m_pv});
      end
      if (div_ack) acks++;
      if (rise_tick) begin
        if (r0 < 0) r0 = cyc;
        else if (r1 < 0) r1 = cyc;
      end
    end
    vectors++;
    if (acks != 1) begin
      miscompares++;
      $display("FAIL double_ack_count got=%0d exp=1", acks);
    end
    vectors++;
    if (r1 - r0 != 8) begin
      miscompares++;
      $display("FAIL double_period got=%0d exp=8", r1 - r0);
    end
  endtask

  task automatic test_div2();
    logic prev;
    bit   seen = 1'b0;
    enable   = 1'b1;
    div_half = 8'd0;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = div_ack;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL div2_ack got=0 exp=1");
    end
    prev = clk_out;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (clk_out === prev || rise_tick !== clk_out || fall_tick !== !clk_out) begin
        miscompares++;
        $display("FAIL div2_alternate cyc=%0d got=%b%b%b exp=%b%b%b", cyc, clk_out, rise_tick, fall_tick, !prev, !prev, prev);
      end
      prev = clk_out;
    end
  endtask

  task automatic test_enable_pause();
    int   ack_c = -1, fall_c = -1, ack2_c = -1;
    logic held;
    enable   = 1'b1;
    div_half = 8'd20;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    for (int i = 0; i < 40 && ack_c < 0; i++) begin
      tick();
      if (div_ack) ack_c = cyc;
    end
    for (int i = 0; i < 5; i++) tick();
    held = clk_out;
    div_half = 8'd2;
    for (int i = 0; i < 37; i++) begin
      enable   = 1'b0;
      div_load = (i == 10);
      tick();
      vectors++;
      if (clk_out !== held || rise_tick !== 1'b0 || fall_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_frozen cyc=%0d got=%b%b%b exp=%b00", cyc, clk_out, rise_tick, fall_tick, held);
      end
    end
    div_load = 1'b0;
    enable   = 1'b1;
    for (int i = 0; i < 120 && ack2_c < 0; i++) begin
      tick();
      vectors++;
      if ({clk_out, rise_tick, fall_tick, div_ack, pend_valid} !== {m_lvl, m_rise, m_fall, m_ack, m_pv}) begin
        miscompares++;
        $display("FAIL pause_model cyc=%0d got=%b exp=%b", cyc, {clk_out, rise_tick, fall_tick, div_ack, pend_valid}, {m_lvl, m_rise, m_fall, m_ack, m_pv});
      end
      if (fall_tick && fall_c < 0) begin
        fall_c = cyc;
        vectors++;
        if (pend_valid !== 1'b1 || div_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL pause_fall_no_apply got=%b%b exp=10", pend_valid, div_ack);
        end
      end
      if (div_ack) ack2_c = cyc;
    end
    vectors++;
    if (ack_c < 0 || fall_c - ack_c != 58) begin
      miscompares++;
      $display("FAIL pause_phase_len got=%0d exp=58", fall_c - ack_c);
    end
    vectors++;
    if (fall_c < 0 || ack2_c - fall_c != 21) begin
      miscompares++;
      $display("FAIL pause_load_apply got=%0d exp=21", ack2_c - fall_c);
    end
  endtask

  task automatic test_same_cycle_load();
    int ack_c = -1, fall_c = -1;
    enable   = 1'b1;
    div_half = 8'd5;
    div_load = 1'b1;
    tick();
    div_half = 8'd6;
    for (int i = 0; i < 40 && fall_c < 0; i++) begin
      div_load = (ack_c < 0) && !m_lvl && (m_left == 1);
      tick();
      div_load = 1'b0;
      if (div_ack && ack_c < 0) begin
        ack_c = cyc;
        vectors++;
        if (pend_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL same_cycle_pend got=%b exp=1", pend_valid);
        end
      end else if (ack_c >= 0 && fall_tick) begin
        fall_c = cyc;
      end
    end
    vectors++;
    if (ack_c < 0 || fall_c - ack_c != 6) begin
      miscompares++;
      $display("FAIL same_cycle_old_applied got=%0d exp=6", fall_c - ack_c);
    end
  endtask

  task automatic test_reset_pending();
    int fall_c = -1;
    enable   = 1'b1;
    div_half = 8'd9;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({clk_out, rise_tick, fall_tick, div_ack, pend_valid} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_pending_state got=%b exp=%b", {clk_out, rise_tick, fall_tick, div_ack, pend_valid}, 5'b10000);
    end
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 260 && fall_c < 0; i++) begin
      tick();
      if (fall_tick) fall_c = cyc;
    end
    vectors++;
    if (fall_c != 250) begin
      miscompares++;
      $display("FAIL reset_pending_default got=%0d exp=250", fall_c);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 19) == 0);
      div_half = CNT_W'($urandom_range(0, 7));
      reset    = ($urandom_range(0, 999) == 0);
      tick();
      vectors++;
      if ({clk_out, rise_tick, fall_tick, div_ack, pend_valid} !== {m_lvl, m_rise, m_fall, m_ack, m_pv}) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {clk_out, rise_tick, fall_tick, div_ack, pend_valid}, {m_lvl, m_rise, m_fall, m_ack, m_pv});
      end
    end
    reset    = 1'b0;
    div_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_load();
    test_double_load();
    test_div2();
    test_enable_pause();
    test_same_cycle_load();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
